ro_edge_counter: RTL

//   Counts rising edges of a ring-oscillator output during the measurement window set by
//   the counter controller's counteren/counterrst.

---
 rtl/ro_edge_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - ring-oscillator edge counter with latched valid/ready readout
// Macro RO_CNT_SATURATE_EN: counter sticks at all-ones on overflow instead of wrapping.
module ro_edge_counter #(
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ro_in,
   input  logic                 counteren,
   input  logic                 counterrst,
   input  logic                 count_ready,
   output logic                 count_valid,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic                 count_ovf,
   output logic [1:0]           cnt_state
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_COUNT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;
   localparam logic [1:0] ST_HOLD  = 2'b11;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [1:0]             state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0]   count_out_q, count_out_d;
   logic                   count_ovf_q, count_ovf_d;
   logic                   ro_edge;
   logic [CNT_WIDTH-1:0]   cnt_inc;

   assign ro_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

   // Value the counter takes on an edge at all-ones depends on the build option.
   always_comb begin
      cnt_inc = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) begin
`ifdef RO_CNT_SATURATE_EN
         cnt_inc = CNT_MAX;
`else
         cnt_inc = '0;
`endif
      end
   end

   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], ro_in};
      prev_d      = sync_q[SYNC_STAGES-1];
      state_d     = state_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      count_out_d = count_out_q;
      count_ovf_d = count_ovf_q;

      if (counterrst) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (counteren) state_d = ST_COUNT;
            end
            ST_COUNT: begin
               if (!counteren) begin
                  state_d     = ST_DONE;
                  count_out_d = cnt_q;
                  count_ovf_d = ovf_q;
               end else if (ro_edge) begin
                  cnt_d = cnt_inc;
                  if (cnt_q == CNT_MAX) ovf_d = 1'b1;
               end
            end
            ST_DONE: begin
               if (count_ready) state_d = ST_HOLD;
            end
            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         prev_q      <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         count_out_q <= '0;
         count_ovf_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         count_out_q <= count_out_d;
         count_ovf_q <= count_ovf_d;
      end
   end

   assign count_valid = (state_q == ST_DONE);
   assign count_out   = count_out_q;
   assign count_ovf   = count_ovf_q;
   assign cnt_state   = state_q;

endmodule
